// File: rtl/seq_evt_pkg.sv
// Shared state encoding and default widths for the sequence event counter.
package seq_evt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count register: clear has priority, increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/sequence_event_counter.sv
// Counts detect pulses over back-to-back programmable windows, reports each
// window's count with a one-cycle strobe and raises a sticky threshold alarm.
module sequence_event_counter
  import seq_evt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset_ah_in,
  input  logic             enable_in,
  input  logic             detect_in,
  input  logic [WIN_W-1:0] window_len_in,
  input  logic [CNT_W-1:0] threshold_in,
  input  logic             alarm_clr_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid_out,
  output logic             alarm_out
);

  // A zero-length window behaves as a one-cycle window.
  function automatic logic [WIN_W-1:0] len_or_one(input logic [WIN_W-1:0] len);
    return (len == {WIN_W{1'b0}}) ? WIN_W'(1) : len;
  endfunction

  state_t           state_r, state_next_s;
  logic [WIN_W-1:0] win_cnt_r;
  logic [WIN_W-1:0] win_len_r;
  logic [CNT_W-1:0] ev_cnt_s;
  logic [CNT_W-1:0] rpt_s;
  logic             in_count_s;
  logic             win_end_s;
  logic             ev_clr_s;
  logic             ev_inc_s;
  logic [CNT_W-1:0] count_r;
  logic             valid_r;
  logic             alarm_r;

  assign in_count_s = (state_r == ST_COUNT);
  assign win_end_s  = in_count_s && (win_cnt_r == (win_len_r - WIN_W'(1)));
  // Leaving COUNT also clears, so IDLE always sees a zero event count.
  assign ev_clr_s   = !in_count_s || win_end_s || !enable_in;
  assign ev_inc_s   = in_count_s && detect_in;
  // The last window cycle's detect is folded into the report.
  assign rpt_s      = (ev_cnt_s == {CNT_W{1'b1}}) ? ev_cnt_s : (ev_cnt_s + CNT_W'(detect_in));

  sat_counter #(.W(CNT_W)) u_ev_cnt (
    .clk   (clk),
    .rst_n (reset_ah_in),
    .clr   (ev_clr_s),
    .inc   (ev_inc_s),
    .cnt   (ev_cnt_s)
  );

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = enable_in ? ST_ARM : ST_IDLE;
      ST_ARM:   state_next_s = enable_in ? ST_COUNT : ST_IDLE;
      ST_COUNT: state_next_s = enable_in ? ST_COUNT : ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State, window counter and window-length capture.
  always_ff @(posedge clk or negedge reset_ah_in) begin
    if (!reset_ah_in) begin
      state_r   <= ST_IDLE;
      win_cnt_r <= {WIN_W{1'b0}};
      win_len_r <= {WIN_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_ARM) || win_end_s) begin
        win_len_r <= len_or_one(window_len_in);
      end else begin
        win_len_r <= win_len_r;
      end
      if (in_count_s && !win_end_s && enable_in) begin
        win_cnt_r <= win_cnt_r + WIN_W'(1);
      end else begin
        win_cnt_r <= {WIN_W{1'b0}};
      end
    end
  end

  // Report outputs and sticky alarm; a set on the report edge beats a clear.
  always_ff @(posedge clk or negedge reset_ah_in) begin
    if (!reset_ah_in) begin
      count_r <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      valid_r <= win_end_s;
      if (win_end_s) begin
        count_r <= rpt_s;
      end else begin
        count_r <= count_r;
      end
      if (win_end_s && (threshold_in != {CNT_W{1'b0}}) && (rpt_s >= threshold_in)) begin
        alarm_r <= 1'b1;
      end else if (alarm_clr_in) begin
        alarm_r <= 1'b0;
      end else begin
        alarm_r <= alarm_r;
      end
    end
  end

  assign count_out       = count_r;
  assign count_valid_out = valid_r;
  assign alarm_out       = alarm_r;

endmodule

// File: tb/tb_sequence_event_counter.sv
// Directed scoreboard bench: expected reports are queued by the stimulus and
// popped by a monitor whenever count_valid_out is seen.
module tb_sequence_event_counter;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             alarm;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_ah_in;
  logic             enable_in;
  logic             detect_in;
  logic [WIN_W-1:0] window_len_in;
  logic [CNT_W-1:0] threshold_in;
  logic             alarm_clr_in;
  logic [CNT_W-1:0] count_out;
  logic             count_valid_out;
  logic             alarm_out;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  sequence_event_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk             (clk),
    .reset_ah_in     (reset_ah_in),
    .enable_in       (enable_in),
    .detect_in       (detect_in),
    .window_len_in   (window_len_in),
    .threshold_in    (threshold_in),
    .alarm_clr_in    (alarm_clr_in),
    .count_out       (count_out),
    .count_valid_out (count_valid_out),
    .alarm_out       (alarm_out)
  );

  always #5 clk = ~clk;

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_ah_in === 1'b1 && count_valid_out === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_report: count_out=%0d with no report expected", count_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (count_out !== e.cnt || alarm_out !== e.alarm) begin
          n_err++;
          $display("FAIL report: got count=%0d alarm=%0b, want count=%0d alarm=%0b",
                   count_out, alarm_out, e.cnt, e.alarm);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input logic d);
    detect_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic a);
    exp_t e;
    e.cnt   = CNT_W'(c);
    e.alarm = a;
    exp_q.push_back(e);
  endtask

  // IDLE -> ARM -> first COUNT cycle.
  task automatic start(input int len);
    window_len_in = WIN_W'(len);
    enable_in     = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
  endtask

  task automatic stop();
    enable_in = 1'b0;
    cyc(1'b0);
  endtask

  initial begin
    reset_ah_in   = 1'b0;
    enable_in     = 1'b0;
    detect_in     = 1'b0;
    window_len_in = '0;
    threshold_in  = '0;
    alarm_clr_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_ah_in = 1'b1;
    cyc(1'b0);
    chk("reset_count", int'(count_out), 0);
    chk("reset_valid", int'(count_valid_out), 0);
    chk("reset_alarm", int'(alarm_out), 0);

    // 1: window 8, detects at COUNT cycles 1 and 5
    threshold_in = 8'd0;
    start(8);
    push(2, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cyc((i == 1) || (i == 5));
      if (i == 7) chk("t1_no_early_valid", int'(count_valid_out), 0);
      if (i == 8) chk("t1_valid_at_edge8", int'(count_valid_out), 1);
    end
    stop();
    chk("t1_valid_one_cycle", int'(count_valid_out), 0);

    // 2: threshold 3, four detects -> alarm; clear; then set+clear same edge
    threshold_in = 8'd3;
    start(4);
    push(4, 1'b1);
    repeat (4) cyc(1'b1);
    alarm_clr_in = 1'b1;
    stop();
    alarm_clr_in = 1'b0;
    chk("t2_alarm_cleared", int'(alarm_out), 0);
    start(4);
    push(4, 1'b1);
    repeat (3) cyc(1'b1);
    alarm_clr_in = 1'b1;
    cyc(1'b1);
    alarm_clr_in = 1'b0;
    chk("t2_set_beats_clear", int'(alarm_out), 1);
    stop();
    cyc(1'b0);
    cyc(1'b0);
    chk("t2_alarm_sticky_idle", int'(alarm_out), 1);
    alarm_clr_in = 1'b1;
    cyc(1'b0);
    alarm_clr_in = 1'b0;
    chk("t2_alarm_clear_idle", int'(alarm_out), 0);

    // 3: saturation over a 300-cycle window, then an empty window
    threshold_in = 8'd0;
    start(300);
    push(255, 1'b0);
    repeat (300) cyc(1'b1);
    push(0, 1'b0);
    repeat (300) cyc(1'b0);
    stop();

    // 4: enable dropped at COUNT cycle 6 discards the partial window
    threshold_in = 8'd5;
    start(10);
    repeat (5) cyc(1'b1);
    enable_in = 1'b0;
    cyc(1'b1);
    cyc(1'b0);
    chk("t4_no_partial_report", int'(count_out), 0);
    start(10);
    push(3, 1'b0);
    for (int i = 1; i <= 10; i++) cyc((i == 1) || (i == 3) || (i == 5));
    stop();
    chk("t4_below_threshold", int'(alarm_out), 0);

    // 5: window 0 acts as 1 -> a report every COUNT cycle
    threshold_in = 8'd0;
    start(0);
    push(1, 1'b0);
    push(0, 1'b0);
    push(1, 1'b0);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);
    push(0, 1'b0);
    stop();
    chk("t5_last_count", int'(count_out), 0);

    // 6: async reset mid-window clears everything without a clock edge
    threshold_in = 8'd3;
    start(5);
    push(5, 1'b1);
    repeat (5) cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    chk("t6_pre_count", int'(count_out), 5);
    chk("t6_pre_alarm", int'(alarm_out), 1);
    #2;
    reset_ah_in = 1'b0;
    #1;
    chk("t6_rst_count", int'(count_out), 0);
    chk("t6_rst_valid", int'(count_valid_out), 0);
    chk("t6_rst_alarm", int'(alarm_out), 0);
    @(posedge clk);
    #1;
    reset_ah_in = 1'b1;
    enable_in   = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("pending_reports", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sequence_event_counter.md
Name: sequence_event_counter

Overview:
- Downstream consumer of the non-overlapping 1010 Mealy sequence detector. Takes its one-cycle detect pulse and counts detections over a programmable window of clock cycles.
- At the end of each window it reports the count with a one-cycle valid strobe.
- Raises a sticky alarm when a reported count reaches a programmable threshold.
- Feeds status/interrupt logic in the fsm test harness.

Parameters:
- CNT_W, 8: width of the event counter and of count_out/threshold_in; count saturates at 2^CNT_W-1.
- WIN_W, 16: width of the window-length counter and window_len_in.

Ports:
- clk  input  1  system clock, rising edge.
- reset_ah_in  input  1  asynchronous, active-low reset (asserted when 0).
- enable_in  input  1  1 = windows run back-to-back; 0 = idle.
- detect_in  input  1  detect pulse from the sequence detector; each high cycle counts as one event.
- window_len_in  input  WIN_W  window length in cycles; sampled at window start; 0 is treated as 1.
- threshold_in  input  CNT_W  alarm threshold, sampled at report time; 0 disables the alarm.
- alarm_clr_in  input  1  clears alarm_out.
- count_out  output  CNT_W  event count of the last completed window; held until the next report.
- count_valid_out  output  1  one-cycle strobe on the cycle count_out updates.
- alarm_out  output  1  sticky alarm.

Behaviour:
- Reset (async, reset_ah_in=0):
  - state=IDLE; win_cnt=0; ev_cnt=0; win_len_q=0.
  - count_out=0, count_valid_out=0, alarm_out=0.
- States: IDLE, ARM, COUNT (2-bit encoding from package).
- IDLE:
  - Counters held at 0. detect_in is ignored.
  - enable_in=1 -> ARM.
- ARM (one cycle):
  - win_len_q <= max(window_len_in, 1); win_cnt <= 0; ev_cnt <= 0.
  - detect_in is ignored in this cycle.
  - Next state: COUNT if enable_in=1, else IDLE.
- COUNT, each cycle:
  - win_cnt increments.
  - If detect_in=1, ev_cnt increments, saturating at all-ones (no wrap).
- Window end, when win_cnt == win_len_q-1 in COUNT:
  - This cycle's detect_in is included in the report.
  - Next edge: count_out <= sat(ev_cnt + detect_in); count_valid_out=1 for exactly one cycle.
  - win_cnt <= 0; ev_cnt <= 0; win_len_q <= max(window_len_in, 1). No gap cycle: the next window's first cycle is the cycle after the last one.
- Latency: count_valid_out rises 1 cycle after the last window cycle. A window of N starting in COUNT cycle k reports at edge k+N.
- enable_in=0 while in COUNT:
  - Next edge -> IDLE; the partial window is discarded, with no count_valid_out.
  - If that cycle is also a window end, the report still occurs (the completed window is reported), then -> IDLE.
- Alarm:
  - On a report edge, if threshold_in != 0 and reported count >= threshold_in, alarm_out <= 1.
  - alarm_clr_in=1 clears alarm_out at the next edge.
  - Set and clear on the same edge: set wins.
  - alarm_out persists through IDLE. Only reset or a clear drops it.
- Saturation: once ev_cnt reaches all-ones, further detects are ignored for that window; the report shows all-ones.
- Reset mid-window: immediate async return to the reset values above; no report.
- count_valid_out is never high in two consecutive cycles unless win_len_q=1. With win_len_q=1, it is high every cycle while in COUNT.

Decomposition:
- Package seq_evt_pkg: state typedef/localparams (ST_IDLE=2'd0, ST_ARM=2'd1, ST_COUNT=2'd2); default widths.
- Sub-module sat_counter (width-parameterised, with sync clear, increment enable, and saturation at all-ones). Used for ev_cnt.
- The window counter stays inline.

Test Plan:
1. Reset, enable=1, window_len=8, detect high at COUNT cycles 1 and 5 -> one report count_out=2, count_valid_out=1 for one cycle at COUNT edge 8; alarm stays 0 (threshold 0).
2. window_len=4, threshold=3, detect high all 4 cycles -> count_out=4, alarm_out=1. Pulse alarm_clr_in -> alarm_out=0 next cycle. Then assert set and clear on the same edge -> alarm_out=1.
3. CNT_W=8, window_len=300, detect held high -> count_out=255 (saturated); next window with detect low -> count_out=0.
4. window_len=10, enable dropped at COUNT cycle 6 -> no count_valid_out; re-enable -> ARM, then a fresh 10-cycle window reports only the new events.
5. window_len=0 -> treated as 1; detect pattern 1,0,1 -> count_valid_out high every COUNT cycle, with count_out=1,0,1.
6. Assert reset_ah_in=0 mid-window with count_out=5 and alarm_out=1 -> all outputs 0 immediately, without waiting for a clock edge.
